reg_bus_responder: RTL
======================

Name: reg_bus_responder

Overview:
- Register-side responder for the control-FSM strobe interface.
- Holds general registers G0–G3, port registers P0/P1 and the program counter.
- Obeys the per-register `*_in`/`*_out` strobes and `PC_inc` issued by instruction FSMs (MOV and siblings): builds the shared internal bus, latches destinations, advances PC, and flags protocol violations (bus contention, undriven writes).
- Sits between the control FSMs and the datapath/IO pins.

Parameters:
- WIDTH, 16, data width of G0–G3, P0, P1, bus and immediate.
- PC_WIDTH, 8, program counter width.
- SYNC_STAGES, 2, synchronizer depth for port_in pins into P1 (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- G0_in, G1_in, G2_in, G3_in, P0_in, P1_in  input  1 each  latch bus into register at this edge.
- G0_out, G1_out, G2_out, G3_out, P0_out, P1_out  input  1 each  drive register onto bus this cycle.
- imm_out  input  1  drive imm_data onto bus (immediate source).
- imm_data  input  WIDTH  immediate value from the instruction word.
- PC_inc  input  1  increment PC at this edge.
- done  input  1  instruction-complete pulse from the control FSM.
- port_in  input  WIDTH  asynchronous external pins, sampled into P1.
- err_clr  input  1  clears sticky error state.
- bus_data  output  WIDTH  current internal bus value (combinational).
- port_out  output  WIDTH  equals P0 register.
- pc  output  PC_WIDTH  program counter.
- instr_count  output  8  completed-instruction counter.
- bus_err  output  1  sticky error flag.
- err_code  output  2  sticky cause bits: [0] contention, [1] undriven write.

Behaviour:
- **Reset (async, rst=1):**
  - G0–G3, P0, P1, pc, instr_count, synchronizer stages, bus_err, err_code all clear to 0.
  - port_out=0.
  - bus_data=0 while no source is asserted.
- **Source count.** N = number of asserted sources among the six `*_out` strobes plus imm_out.
- **bus_data (combinational, same cycle):**
  - N==1: the selected register value, or imm_data.
  - N==0 or N>1: 0.
- **Writes at the rising edge (N==1):**
  - Every asserted `*_in` register loads bus_data.
  - Multiple `*_in` is a legal broadcast.
  - A register with both `_in` and `_out` asserted reloads its own value (no change).
- **Contention (N>1):**
  - All `*_in` writes are inhibited that cycle.
  - err_code[0]<=1, bus_err<=1.
- **Undriven write (N==0 with any `*_in`):**
  - Writes are inhibited.
  - err_code[1]<=1, bus_err<=1.
  - N==0 with no `*_in` is idle, not an error.
- **P1 capture path:**
  - port_in passes through SYNC_STAGES flops.
  - P1 loads the last synchronizer stage every cycle, except when P1_in is asserted.
  - A legal P1_in write has priority for that edge; the capture resumes the next cycle.
  - An inhibited P1_in write (error cycle) still blocks capture that cycle; P1 holds.
- **PC:**
  - PC_inc=1: pc<=pc+1, modulo 2^PC_WIDTH (wraps max→0).
  - PC_inc is independent of bus activity and errors.
- **instr_count:**
  - Increments on each clock with done=1.
  - Saturates at 255.
  - Error cycles still count.
- **Errors:**
  - err_code bits are sticky and OR-accumulate.
  - bus_err = |err_code.
  - err_clr=1 clears both at the edge.
  - If err_clr and a new error occur in the same cycle, the new error wins: the bit is set after the edge.
- **Reset mid-transfer:** all state returns to reset values immediately; strobes active during rst have no effect.
- Latency: bus 0 cycles, register write 1 edge, port_in→P1 SYNC_STAGES+1 edges.

Test Plan:
- **Reset:** rst=1 for 2ns with strobes toggling → all registers 0, pc=0, bus_err=0, bus_data=0.
- **Immediate broadcast then MOV:**
  - imm_out=1, imm_data=16'h00A5, G0_in=G2_in=1 for one edge → G0=G2=16'h00A5.
  - Next cycle G2_out=1, P0_in=1 → port_out=16'h00A5.
- **Contention:**
  - Preload G1=16'h1111, G3=16'h3333.
  - G1_out=G3_out=1, G0_in=1 → bus_data=0, G0 unchanged, err_code=2'b01.
  - Then undriven G0_in alone → err_code=2'b11.
  - err_clr → 2'b00.
- **PC wrap:** 256 PC_inc pulses from reset → pc returns to 8'h00.
- **Port input:**
  - port_in=16'hBEEF → P1=16'hBEEF after 3 edges.
  - While port_in changes, P1_in with imm_data=16'h0001 → P1=16'h0001 for exactly that edge, then recapture.
- **Simultaneous and saturation:**
  - err_clr coincident with contention → err_code[0]=1 after the edge.
  - 260 done pulses → instr_count=255.

Source files
------------

// File: rtl/reg_bus_responder.sv
// Register-side responder for the control-FSM strobe interface: builds the internal
// bus from one-hot source strobes, latches destinations, advances PC and flags bus misuse.
module reg_bus_responder #(
    parameter int WIDTH       = 16,
    parameter int PC_WIDTH    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                G0_in,
    input  logic                G1_in,
    input  logic                G2_in,
    input  logic                G3_in,
    input  logic                P0_in,
    input  logic                P1_in,
    input  logic                G0_out,
    input  logic                G1_out,
    input  logic                G2_out,
    input  logic                G3_out,
    input  logic                P0_out,
    input  logic                P1_out,
    input  logic                imm_out,
    input  logic [WIDTH-1:0]    imm_data,
    input  logic                PC_inc,
    input  logic                done,
    input  logic [WIDTH-1:0]    port_in,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    bus_data,
    output logic [WIDTH-1:0]    port_out,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          instr_count,
    output logic                bus_err,
    output logic [1:0]          err_code
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    logic [WIDTH-1:0] g0, g1, g2, g3, p0, p1;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [2:0]       n_src;
    logic             any_in;
    logic             write_ok;
    logic             contention;
    logic             undriven;

    assign n_src = {2'b00, G0_out} + {2'b00, G1_out} + {2'b00, G2_out} + {2'b00, G3_out}
                 + {2'b00, P0_out} + {2'b00, P1_out} + {2'b00, imm_out};
    assign any_in     = G0_in | G1_in | G2_in | G3_in | P0_in | P1_in;
    assign write_ok   = (n_src == 3'd1);
    assign contention = (n_src > 3'd1);
    assign undriven   = (n_src == 3'd0) && any_in;

    // With exactly one source the AND-OR mux equals that source; any other count reads as 0.
    always_comb begin
        bus_data = '0;
        if (write_ok) begin
            bus_data = ({WIDTH{G0_out}}  & g0) | ({WIDTH{G1_out}} & g1)
                     | ({WIDTH{G2_out}}  & g2) | ({WIDTH{G3_out}} & g3)
                     | ({WIDTH{P0_out}}  & p0) | ({WIDTH{P1_out}} & p1)
                     | ({WIDTH{imm_out}} & imm_data);
        end
    end

    assign port_out = p0;
    assign bus_err  = |err_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0 <= '0;
            g1 <= '0;
            g2 <= '0;
            g3 <= '0;
            p0 <= '0;
        end else if (write_ok) begin
            if (G0_in) g0 <= bus_data;
            if (G1_in) g1 <= bus_data;
            if (G2_in) g2 <= bus_data;
            if (G3_in) g3 <= bus_data;
            if (P0_in) p0 <= bus_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= port_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // P1_in always suppresses pin capture for its edge, even when the write itself is inhibited.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
        end else if (P1_in) begin
            if (write_ok) p1 <= bus_data;
        end else begin
            p1 <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            instr_count <= '0;
        end else begin
            if (PC_inc) pc <= pc + PC_ONE;
            if (done && (instr_count != 8'hFF)) instr_count <= instr_count + 8'd1;
        end
    end

    // A fresh error in the clearing cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_code <= 2'b00;
        end else begin
            err_code <= (err_clr ? 2'b00 : err_code) | {undriven, contention};
        end
    end

endmodule
